regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard.
- Provides N combinational read ports and M write ports, with optional same-cycle write-to-read bypass.
- Tracks one busy bit per architectural register, so decode/issue can detect RAW hazards on results not yet written back.
- Sits between decode/issue (reads, allocates destinations) and writeback (writes, releases destinations).

Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, >=2)
- NUM_RD_PORTS, 2, number of read ports (>=1)
- NUM_WR_PORTS, 1, number of write ports (>=1)
- BYPASS_EN, 1, 1 = same-cycle write data and release are forwarded to read ports
- ZERO_REG_EN, 1, 1 = register 0 hardwired to zero, never busy

Ports (AW = $clog2(NUM_REGS), CW = $clog2(NUM_REGS+1)):
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- rd_addr_i  in  NUM_RD_PORTS*AW  read addresses; port k = bits [k*AW +: AW]
- rd_data_o  out  NUM_RD_PORTS*DATA_WIDTH  read data, packed the same way
- rd_busy_o  out  NUM_RD_PORTS  read register has a pending producer
- wr_en_i  in  NUM_WR_PORTS  per-port write enable
- wr_addr_i  in  NUM_WR_PORTS*AW  write addresses
- wr_data_i  in  NUM_WR_PORTS*DATA_WIDTH  write data
- alloc_en_i  in  1  mark destination busy (issue)
- alloc_addr_i  in  AW  destination being allocated
- flush_i  in  1  clear all busy bits (pipeline flush)
- busy_cnt_o  out  CW  number of busy registers

Behaviour:
- Reset rst_n_i is asynchronous, active-low; clock clk_i, rising edge.
- In reset: all registers = 0, all busy bits = 0; rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0.
- Write: at posedge, each port with wr_en_i=1 stores its data.
  - Address 0 is ignored when ZERO_REG_EN=1.
  - Several ports writing the same address in one cycle: the highest-index port wins.
- Read: combinational, zero latency.
  - Address 0 with ZERO_REG_EN=1 returns 0.
  - With BYPASS_EN=1, an active write to the read address in the same cycle returns that port's wr_data_i (highest index wins).
  - Otherwise the stored value is returned.
- Scoreboard:
  - A write to addr clears busy[addr] at the next edge (release).
  - alloc_en_i sets busy[alloc_addr_i] at the next edge; allocation of register 0 is ignored when ZERO_REG_EN=1.
  - Alloc and release of the same address in one cycle: alloc wins, and busy stays 1 (new producer).
  - Allocating an already-busy register is legal; the bit stays 1.
  - flush_i clears every busy bit at the next edge and overrides any alloc in that cycle. Writes in a flush cycle still update data.
- rd_busy_o[k] = busy[addr_k], except:
  - forced 0 for register 0 when ZERO_REG_EN=1;
  - with BYPASS_EN=1, also 0 when a write to addr_k is active this cycle.
- busy_cnt_o is registered: the population count of the busy vector, updated with it (one-cycle view of the current state).
- Reset asserted mid-operation: data, busy and count return to 0 asynchronously; no pending state survives.

Decomposition:
- Shared package pkg_config:
  - DATA_WIDTH and NUM_REGISTER defaults;
  - typedef reg_addr_t (logic [$clog2(NUM_REGISTER)-1:0]);
  - typedef reg_data_t.
- One sub-module, regfile_scoreboard: busy vector, alloc/release/flush priority and busy_cnt_o. It takes the write-port enables/addresses and the alloc/flush inputs.
- The top level holds the storage array, write-port priority and read/bypass muxing.

Test Plan:
- Reset, then read all 32 addresses on both ports -> data 0, busy 0, busy_cnt_o=0; assert rst_n_i mid-run after writes -> all return to 0 immediately.
- Write 0xDEADBEEF to r5; next cycle read r5 on port 0 and r0 on port 1 -> 0xDEADBEEF and 0. Write 0x1234 to r0 -> r0 still reads 0.
- BYPASS_EN=1: write 0xA5A5A5A5 to r7 and read r7 in the same cycle -> rd_data_o = 0xA5A5A5A5, rd_busy_o=0. With BYPASS_EN=0 the same cycle returns the old value.
- NUM_WR_PORTS=2: both ports write r9 (0x11, 0x22) -> r9 = 0x22. Ports write r9=0x33 and r10=0x44 -> both stored.
- Alloc r3 -> next cycle rd_busy_o=1 for r3, busy_cnt_o=1. Alloc r3 and write r3 in the same cycle -> busy stays 1. Write r3 alone -> busy 0, count 0.
- Alloc r4, r6, r8 over three cycles -> busy_cnt_o=3. flush_i with alloc r12 in the same cycle -> all busy 0, count 0, r12 not busy. Alloc r0 -> ignored.

Source files
------------

// File: rtl/pkg_config.sv
// rtl/pkg_config.sv - shared defaults and types for the register file slice
package pkg_config;

  localparam int DATA_WIDTH   = 32;
  localparam int NUM_REGISTER = 32;

  typedef logic [$clog2(NUM_REGISTER)-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]           reg_data_t;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// rtl/regfile_mp_sb_scoreboard.sv - pending-write busy vector with registered population count
module regfile_scoreboard
  import pkg_config::*;
#(
  parameter int NUM_REGS     = NUM_REGISTER,
  parameter int NUM_WR_PORTS = 1,
  parameter int ZERO_REG_EN  = 1,
  parameter int AW           = $clog2(NUM_REGS),
  parameter int CW           = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_WR_PORTS-1:0]    wr_en_i,
  input  logic [NUM_WR_PORTS*AW-1:0] wr_addr_i,
  input  logic                       alloc_en_i,
  input  logic [AW-1:0]              alloc_addr_i,
  input  logic                       flush_i,
  output logic [NUM_REGS-1:0]        busy_o,
  output logic [CW-1:0]              busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;

  // Release first, then alloc, so a new producer in the same cycle keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en_i[p]) busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
    end
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    if (ZERO_REG_EN != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and pending-write scoreboard
module regfile_mp_sb
  import pkg_config::*;
#(
  parameter int DATA_WIDTH   = pkg_config::DATA_WIDTH,
  parameter int NUM_REGS     = NUM_REGISTER,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS_EN    = 1,
  parameter int ZERO_REG_EN  = 1,
  parameter int AW           = $clog2(NUM_REGS),
  parameter int CW           = $clog2(NUM_REGS + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]            rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]            wr_en_i,
  input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
  input  logic                               alloc_en_i,
  input  logic [AW-1:0]                      alloc_addr_i,
  input  logic                               flush_i,
  output logic [CW-1:0]                      busy_cnt_o
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  regfile_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .ZERO_REG_EN  (ZERO_REG_EN),
    .AW           (AW),
    .CW           (CW)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .flush_i      (flush_i),
    .busy_o       (busy),
    .busy_cnt_o   (busy_cnt_o)
  );

  // Ports are walked in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_en_i[p] && !(ZERO_REG_EN != 0 && wr_addr_i[p*AW +: AW] == '0))
          mem[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  bsy;

    assign addr = rd_addr_i[k*AW +: AW];

    always_comb begin
      data = mem[addr];
      bsy  = busy[addr];
      if (BYPASS_EN != 0) begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == addr) begin
            data = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            bsy  = 1'b0;
          end
        end
      end
      if (ZERO_REG_EN != 0 && addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
      // Bypass paths would otherwise leak write data while reset is held.
      if (!rst_n_i) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy_o[k]                          = bsy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - self-checking bench for regfile_mp_sb (bypass and non-bypass instances)
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wen;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        al;
  logic [4:0]  aa;
  logic        fl;
  logic [4:0]  ra [2];

  logic [9:0]  rd_addr, wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [5:0]  cnt_b, cnt_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs_m [32];
  bit          busy_m [32];

  assign rd_addr = {ra[1], ra[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};

  always #5 clk = ~clk;

  regfile_mp_sb #(.NUM_WR_PORTS(2), .BYPASS_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(rd_busy_b), .wr_en_i(wen), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(al), .alloc_addr_i(aa), .flush_i(fl), .busy_cnt_o(cnt_b)
  );

  regfile_mp_sb #(.NUM_WR_PORTS(2), .BYPASS_EN(0)) dut_nb (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
    .rd_busy_o(rd_busy_n), .wr_en_i(wen), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(al), .alloc_addr_i(aa), .flush_i(fl), .busy_cnt_o(cnt_n)
  );

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        al;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1, input logic alc,
                              input logic [4:0] alca, input logic f, input logic [4:0] r0,
                              input logic [4:0] r1, input logic [31:0] x0, input logic [31:0] x1,
                              input logic [1:0] xb, input logic [5:0] xc);
    vec_t v;
    v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.al = alc; v.aa = alca; v.fl = f; v.ra0 = r0; v.ra1 = r1;
    v.e0 = x0; v.e1 = x1; v.eb = xb; v.ec = xc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    logic [31:0] r;
    if (a == 5'd0) return 32'd0;
    r = regs_m[a];
    if (byp) for (int p = 0; p < 2; p++) if (wen[p] && wa[p] == a) r = wd[p];
    return r;
  endfunction

  function automatic bit m_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp) for (int p = 0; p < 2; p++) if (wen[p] && wa[p] == a) return 1'b0;
    return busy_m[a];
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(busy_m[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = 32'd0;
      busy_m[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < 2; p++) if (wen[p] && wa[p] != 5'd0) regs_m[wa[p]] = wd[p];
    if (fl) begin
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) if (wen[p]) busy_m[wa[p]] = 1'b0;
      if (al && aa != 5'd0) busy_m[aa] = 1'b1;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk("byp_rd_data", rd_data_b[k*32 +: 32], m_rd(ra[k], 1'b1));
      chk("byp_rd_busy", rd_busy_b[k], m_busy(ra[k], 1'b1));
      chk("nb_rd_data", rd_data_n[k*32 +: 32], m_rd(ra[k], 1'b0));
      chk("nb_rd_busy", rd_busy_n[k], m_busy(ra[k], 1'b0));
    end
    chk("byp_busy_cnt", cnt_b, m_cnt());
    chk("nb_busy_cnt", cnt_n, m_cnt());
  endtask

  task automatic idle();
    wen = 2'b00; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    al = 1'b0; aa = 0; fl = 1'b0;
  endtask

  task automatic reset_check(input string nm);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a);
      #1;
      chk({nm, "_data"}, rd_data_b, 64'd0);
      chk({nm, "_busy"}, {rd_busy_b, rd_busy_n}, 4'd0);
      chk({nm, "_data_nb"}, rd_data_n, 64'd0);
    end
    chk({nm, "_cnt"}, {cnt_b, cnt_n}, 12'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra[0] = 0; ra[1] = 0;
    model_reset();
    #1;
    reset_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //        wen    wa0    wd0           wa1    wd1    al    aa     fl    ra0    ra1    e0            e1            eb     ec
    vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 6'd0);
    vecs[1]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 6'd0);
    vecs[2]  = mk(2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 6'd0);
    vecs[3]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 2'b00, 6'd0);
    vecs[4]  = mk(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 6'd0);
    vecs[5]  = mk(2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h22, 32'h22, 2'b00, 6'd0);
    vecs[6]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd7, 32'h22, 32'hA5A5A5A5, 2'b00, 6'd0);
    vecs[7]  = mk(2'b11, 5'd9, 32'h33, 5'd10, 32'h44, 1'b0, 5'd0, 1'b0, 5'd9, 5'd10, 32'h33, 32'h44, 2'b00, 6'd0);
    vecs[8]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd10, 32'h33, 32'h44, 2'b00, 6'd0);
    vecs[9]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'd0, 32'd0, 2'b00, 6'd0);
    vecs[10] = mk(2'b01, 5'd3, 32'h77, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'h77, 32'h77, 2'b00, 6'd1);
    vecs[11] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h77, 32'h77, 2'b11, 6'd1);
    vecs[12] = mk(2'b01, 5'd3, 32'h88, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h88, 32'h88, 2'b00, 6'd1);
    vecs[13] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h88, 32'h88, 2'b00, 6'd0);
    vecs[14] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd6, 32'd0, 32'd0, 2'b00, 6'd0);
    vecs[15] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd4, 5'd6, 32'd0, 32'd0, 2'b01, 6'd1);
    vecs[16] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 5'd6, 5'd8, 32'd0, 32'd0, 2'b01, 6'd2);
    vecs[17] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b1, 5'd4, 5'd8, 32'd0, 32'd0, 2'b11, 6'd3);
    vecs[18] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd12, 5'd4, 32'd0, 32'd0, 2'b00, 6'd0);
    vecs[19] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd12, 32'd0, 32'd0, 2'b00, 6'd0);

    for (int i = 0; i < 20; i++) begin
      wen = vecs[i].wen; wa[0] = vecs[i].wa0; wd[0] = vecs[i].wd0;
      wa[1] = vecs[i].wa1; wd[1] = vecs[i].wd1;
      al = vecs[i].al; aa = vecs[i].aa; fl = vecs[i].fl;
      ra[0] = vecs[i].ra0; ra[1] = vecs[i].ra1;
      @(negedge clk);
      check_model();
      chk($sformatf("vec%0d_rd0", i), rd_data_b[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data_b[63:32], vecs[i].e1);
      chk($sformatf("vec%0d_busy", i), rd_busy_b, vecs[i].eb);
      chk($sformatf("vec%0d_cnt", i), cnt_b, vecs[i].ec);
      @(posedge clk);
      model_edge();
      #1;
    end

    // Non-bypass instance must show the stored value during a same-cycle write.
    wen = 2'b01; wa[0] = 5'd7; wd[0] = 32'h5A5A5A5A; ra[0] = 5'd7; ra[1] = 5'd7;
    @(negedge clk);
    chk("nb_old_value", rd_data_n[31:0], 32'hA5A5A5A5);
    chk("byp_new_value", rd_data_b[31:0], 32'h5A5A5A5A);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
    idle();

    for (int i = 0; i < 400; i++) begin
      wen = 2'($urandom);
      wa[0] = 5'($urandom_range(0, 15)); wa[1] = 5'($urandom_range(0, 15));
      wd[0] = $urandom; wd[1] = $urandom;
      al = 1'($urandom); aa = 5'($urandom_range(0, 15));
      fl = ($urandom_range(0, 15) == 0);
      ra[0] = 5'($urandom_range(0, 15)); ra[1] = 5'($urandom_range(0, 15));
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Make sure state is nonzero before the asynchronous reset.
    wen = 2'b01; wa[0] = 5'd20; wd[0] = 32'hCAFEF00D; al = 1'b1; aa = 5'd21; fl = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    idle();
    ra[0] = 5'd20; ra[1] = 5'd21;
    #1;
    chk("pre_reset_data", rd_data_b[31:0], 32'hCAFEF00D);
    chk("pre_reset_busy", rd_busy_b[1], 1'b1);
    #1;
    rst_n = 1'b0;
    model_reset();
    reset_check("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ra[0] = 5'd20; ra[1] = 5'd21;
    @(negedge clk);
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
